alu_result_stage: RTL and testbench

- Writeback/condition stage directly downstream of the 8-bit ALU.
- Captures the ALU result and its 4-bit flags.
- Holds the architectural flags register and evaluates branch condition codes against it.
- Buffers register-file writebacks in a 2-entry skid FIFO with valid/ready handshakes on both sides.

---
 rtl/alu_result_stage.sv | 135 +++++++++++++
 tb/tb_alu_result_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU writeback/condition stage: flags register, branch condition evaluation and a 2-entry writeback skid FIFO.
// Optional macro ALU_RESULT_FLAG_BYPASS_EN forwards same-cycle aluFlags into the condition evaluation.
module alu_result_stage #(
    parameter int DATA_WIDTH     = 15,
    parameter int REG_DATA_WIDTH = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [DATA_WIDTH-1:0]     aluResult,
    input  logic [3:0]                aluFlags,
    input  logic                      writeReg,
    input  logic                      writeFlags,
    input  logic [REG_ADDR_WIDTH-1:0] rdAddr,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [REG_DATA_WIDTH-1:0] outData,
    output logic [REG_ADDR_WIDTH-1:0] outRd,
    output logic [3:0]                flagsReg,
    input  logic [3:0]                condCode,
    output logic                      condTrue
);

    // Flag bit order: [3]=V [2]=C(borrow on SUB/CMP) [1]=N [0]=Z
    function automatic logic eval_cond(input logic [3:0] f, input logic [3:0] cc);
        logic z, n, c, v, r;
        z = f[0];
        n = f[1];
        c = f[2];
        v = f[3];
        case (cc)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = !c && !z;
            4'd9:    r = c || z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z && (n == v);
            4'd13:   r = z || (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]                count_q, count_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [REG_DATA_WIDTH-1:0] data_q [2];
    logic [REG_ADDR_WIDTH-1:0] rd_q [2];
    logic [REG_DATA_WIDTH-1:0] last_data_q, last_data_d;
    logic [REG_ADDR_WIDTH-1:0] last_rd_q, last_rd_d;
    logic [3:0]                flags_q, flags_d;
    logic                      accept, push, pop;
    logic [3:0]                cond_flags;
    logic                      unused_hi;

    assign unused_hi = ^aluResult[DATA_WIDTH-1:REG_DATA_WIDTH];

    // Ready depends only on registered count, so there is no ready path from outReady.
    assign inReady  = (count_q != 2'd2);
    assign outValid = (count_q != 2'd0);
    assign accept   = inValid && inReady;
    assign push     = accept && writeReg;
    assign pop      = outValid && outReady;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        last_data_d = last_data_q;
        last_rd_d   = last_rd_q;
        flags_d     = flags_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (pop) begin
            last_data_d = data_q[rd_ptr_q];
            last_rd_d   = rd_q[rd_ptr_q];
        end
        if (accept && writeFlags) begin
            flags_d = aluFlags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            last_data_q <= '0;
            last_rd_q   <= '0;
            flags_q     <= 4'd0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_data_q <= last_data_d;
            last_rd_q   <= last_rd_d;
            flags_q     <= flags_d;
        end
    end

    // Storage needs no reset: an entry is only visible while count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= aluResult[REG_DATA_WIDTH-1:0];
            rd_q[wr_ptr_q]   <= rdAddr;
        end
    end

    // When empty, present the last popped entry (zero after reset).
    assign outData  = outValid ? data_q[rd_ptr_q] : last_data_q;
    assign outRd    = outValid ? rd_q[rd_ptr_q]   : last_rd_q;
    assign flagsReg = flags_q;

`ifdef ALU_RESULT_FLAG_BYPASS_EN
    assign cond_flags = (accept && writeFlags) ? aluFlags : flags_q;
`else
    assign cond_flags = flags_q;
`endif

    assign condTrue = eval_cond(cond_flags, condCode);

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized scoreboard bench for alu_result_stage with a behavioural FIFO/flags model.
module tb_alu_result_stage;
    localparam int DW = 15;
    localparam int RW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inValid, inReady;
    logic [DW-1:0] aluResult;
    logic [3:0]    aluFlags;
    logic          writeReg, writeFlags;
    logic [AW-1:0] rdAddr;
    logic          outValid, outReady;
    logic [RW-1:0] outData;
    logic [AW-1:0] outRd;
    logic [3:0]    flagsReg;
    logic [3:0]    condCode;
    logic          condTrue;

    logic rnd_rdy = 1'b0;
    logic rnd_bit = 1'b0;
    logic rdy_man = 1'b0;
    assign outReady = rnd_rdy ? rnd_bit : rdy_man;

    alu_result_stage #(.DATA_WIDTH(DW), .REG_DATA_WIDTH(RW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady),
        .aluResult(aluResult), .aluFlags(aluFlags),
        .writeReg(writeReg), .writeFlags(writeFlags), .rdAddr(rdAddr),
        .outValid(outValid), .outReady(outReady),
        .outData(outData), .outRd(outRd),
        .flagsReg(flagsReg), .condCode(condCode), .condTrue(condTrue)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] d;
        logic [AW-1:0] a;
    } ent_t;

    ent_t          sb[$];
    logic [3:0]    mflags = 4'd0;
    logic [RW-1:0] last_d = '0;
    logic [AW-1:0] last_a = '0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition pairs: even code = base predicate, odd code = its negation.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cc);
        logic z, n, c, v, base;
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = !c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    // Monitor: checks DUT against the model mid-cycle, then advances the model for the coming edge.
    always @(negedge clk) begin
        logic       acc;
        logic [3:0] ef;
        if (!rst_n) begin
            sb.delete();
            mflags = 4'd0;
            last_d = '0;
            last_a = '0;
        end else begin
            chk("inReady", inReady, sb.size() != 2);
            chk("outValid", outValid, sb.size() != 0);
            if (sb.size() != 0) begin
                chk("outData", outData, sb[0].d);
                chk("outRd", outRd, sb[0].a);
            end else begin
                chk("outData_hold", outData, last_d);
                chk("outRd_hold", outRd, last_a);
            end
            chk("flagsReg", flagsReg, mflags);
            acc = inValid && (sb.size() != 2);
            ef  = mflags;
`ifdef ALU_RESULT_FLAG_BYPASS_EN
            if (acc && writeFlags) ef = aluFlags;
`endif
            chk("condTrue", condTrue, ref_cond(ef, condCode));
            if (outValid && outReady && sb.size() != 0) begin
                last_d = sb[0].d;
                last_a = sb[0].a;
                void'(sb.pop_front());
            end
            if (acc && writeReg) sb.push_back({aluResult[RW-1:0], rdAddr});
            if (acc && writeFlags) mflags = aluFlags;
        end
    end

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [DW-1:0] res, input logic [3:0] fl, input logic wr,
                        input logic wf, input logic [AW-1:0] rd, input logic [3:0] cc);
        int n;
        inValid = 1'b1; aluResult = res; aluFlags = fl;
        writeReg = wr; writeFlags = wf; rdAddr = rd; condCode = cc;
        n = 0;
        @(negedge clk);
        while (!inReady && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: inReady got 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; inValid = 1'b0; aluResult = '0; aluFlags = 4'd0;
        writeReg = 1'b0; writeFlags = 1'b0; rdAddr = '0; condCode = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outValid", outValid, 0);
        chk("rst_inReady", inReady, 1);
        chk("rst_outData", outData, 0);
        chk("rst_outRd", outRd, 0);
        chk("rst_flags", flagsReg, 0);
        rst_n = 1'b1;
        idle(1);

        // ADD 0x7F+0x01 with V and N set
        send(15'h080, 4'b1010, 1'b1, 1'b1, 3'd3, 4'd6);
        inValid = 1'b0;
        chk("add_outValid", outValid, 1);
        chk("add_outData", outData, 8'h80);
        chk("add_outRd", outRd, 3);
        chk("add_flags", flagsReg, 4'b1010);
        chk("add_VS", condTrue, 1);
        condCode = 4'd4;
        #1 chk("add_MI", condTrue, 1);
        rdy_man = 1'b1;
        idle(2);

        // CMP 5-5: flags only, no writeback
        send(15'h000, 4'b0001, 1'b0, 1'b1, 3'd0, 4'd0);
        inValid = 1'b0;
        chk("cmp_outValid", outValid, 0);
        chk("cmp_flags", flagsReg, 4'b0001);
        chk("cmp_EQ", condTrue, 1);
        condCode = 4'd1; #1 chk("cmp_NE", condTrue, 0);
        condCode = 4'd8; #1 chk("cmp_HI", condTrue, 0);
        condCode = 4'd9; #1 chk("cmp_LS", condTrue, 1);
        idle(1);

        // Backpressure: fill both entries, third write held until drain
        rdy_man = 1'b0;
        send(15'h011, 4'd0, 1'b1, 1'b0, 3'd1, 4'd14);
        send(15'h022, 4'd0, 1'b1, 1'b0, 3'd2, 4'd14);
        chk("bp_full_inReady", inReady, 0);
        fork
            send(15'h033, 4'd0, 1'b1, 1'b0, 3'd3, 4'd14);
            begin
                repeat (3) @(posedge clk);
                #2 rdy_man = 1'b1;
            end
        join
        idle(4);
        chk("bp_drained", outValid, 0);
        chk("bp_hold_last", outData, 8'h33);

        // Streaming with simultaneous push/pop at count==1
        for (int i = 1; i <= 8; i++) begin
            send(DW'(i), 4'd0, 1'b1, 1'b0, AW'(i), 4'd15);
            chk("stream_inReady", inReady, 1);
        end
        idle(3);

        // Asynchronous reset mid-operation
        rdy_man = 1'b0;
        send(15'h0AA, 4'b1111, 1'b1, 1'b1, 3'd5, 4'd14);
        send(15'h0BB, 4'b0000, 1'b1, 1'b0, 3'd6, 4'd0);
        inValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outValid", outValid, 0);
        chk("arst_inReady", inReady, 1);
        chk("arst_flags", flagsReg, 0);
        chk("arst_outData", outData, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_man = 1'b1;
        idle(2);

        // Same-cycle flag forwarding (or lack of it)
        send(15'h000, 4'b0000, 1'b0, 1'b1, 3'd0, 4'd0);
        inValid = 1'b1; aluFlags = 4'b0001; writeReg = 1'b0; writeFlags = 1'b1; condCode = 4'd0;
        #2;
`ifdef ALU_RESULT_FLAG_BYPASS_EN
        chk("bypass_same_cycle", condTrue, 1);
`else
        chk("bypass_same_cycle", condTrue, 0);
`endif
        @(posedge clk);
        #1 inValid = 1'b0;
        chk("bypass_next_cycle", condTrue, 1);
        idle(1);

        // Random traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(DW'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), AW'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_rdy = 1'b0;
        rdy_man = 1'b1;
        idle(6);
        chk("final_empty", outValid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
